// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys fetched
// from an external store addressed by o_rk_idx.
module aes128_inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [127:0] i_data_in,
  output logic [3:0]   o_rk_idx,
  input  logic [127:0] i_rk,
  output logic         o_busy,
  output logic         o_done,
  output logic [127:0] o_data_out
);

  localparam logic [3:0] LastKey = 4'(NR);

  // Inverse S-box, entry x at bits [2047-8x -: 8].
  localparam logic [2047:0] InvSboxTab = {
    256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
    256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
    256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
    256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
    256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
    256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
    256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
    256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
  };

  typedef enum logic [0:0] {StIdle, StRun} ctrl_e;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return InvSboxTab[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; state[r][c] is byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8 * i +: 8] = inv_sbox(s[8 * i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31 - 8 * r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
    end
    return o;
  endfunction

  ctrl_e        r_ctrl, w_ctrl_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic [127:0] r_blk, w_blk_nxt;
  logic [127:0] r_data_out, w_data_out_nxt;
  logic         r_done, w_done_nxt;
  logic         r_busy, w_busy_nxt;

  logic [127:0] w_ark;
  logic [127:0] w_imc;

  assign w_ark = inv_sub_bytes(inv_shift_rows(r_blk)) ^ i_rk;
  assign w_imc = inv_mix_columns(w_ark);

  always_comb begin
    w_ctrl_nxt     = r_ctrl;
    w_cnt_nxt      = r_cnt;
    w_blk_nxt      = r_blk;
    w_data_out_nxt = r_data_out;
    w_done_nxt     = 1'b0;
    w_busy_nxt     = r_busy;
    unique case (r_ctrl)
      StIdle: begin
        if (i_start) begin
          w_blk_nxt  = i_data_in ^ i_rk;
          w_cnt_nxt  = LastKey - 4'd1;
          w_ctrl_nxt = StRun;
          w_busy_nxt = 1'b1;
        end
      end
      StRun: begin
        if (r_cnt == 4'd0) begin
          w_data_out_nxt = w_ark;
          w_done_nxt     = 1'b1;
          w_busy_nxt     = 1'b0;
          w_cnt_nxt      = LastKey;
          w_ctrl_nxt     = StIdle;
        end else begin
          w_blk_nxt = w_imc;
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl     <= StIdle;
      r_cnt      <= LastKey;
      r_blk      <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_cnt      <= w_cnt_nxt;
      r_blk      <= w_blk_nxt;
      r_data_out <= w_data_out_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Address depends only on registered state, so the key store sees it stable all cycle.
  assign o_rk_idx   = (r_ctrl == StRun) ? r_cnt : LastKey;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_data_out = r_data_out;

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Bench for aes128_inv_cipher_iter: FIPS-197 vectors against a transaction-level model
// built from GF(2^8) arithmetic, with directed protocol scenarios.
module tb_aes128_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [127:0] i_data_in = '0;
  logic [3:0]   o_rk_idx;
  logic [127:0] i_rk;
  logic         o_busy;
  logic         o_done;
  logic [127:0] o_data_out;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk_tab [2][11];
  logic         ks = 1'b0;

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_inv_cipher_iter #(.NR(10)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_data_in  (i_data_in),
    .o_rk_idx   (o_rk_idx),
    .i_rk       (i_rk),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_data_out (o_data_out)
  );

  always #5 clk = ~clk;

  assign i_rk = (o_rk_idx <= 4'd10) ? rk_tab[ks][o_rk_idx] : '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  // Forward S-box from the field inverse (x^254) and the affine map.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input logic ksel, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[ksel][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic ksel);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   tmp;
    logic [127:0] blk;
    logic [127:0] k;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    blk = ct ^ rk_tab[ksel][10];
    for (int n = 0; n < 16; n++) s[n % 4][n / 4] = blk[127 - 8 * n -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 1; r < 4; r++) begin
        for (int j = 0; j < r; j++) begin
          tmp = s[r][3]; s[r][3] = s[r][2]; s[r][2] = s[r][1]; s[r][1] = s[r][0]; s[r][0] = tmp;
        end
      end
      k = rk_tab[ksel][rnd];
      for (int n = 0; n < 16; n++) s[n % 4][n / 4] = isb[s[n % 4][n / 4]] ^ k[127 - 8 * n -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            t[r][c] = 8'h00;
            for (int j = 0; j < 4; j++) t[r][c] = t[r][c] ^ gmul(coef[(j - r + 4) % 4], s[j][c]);
          end
        end
        s = t;
      end
    end
    for (int n = 0; n < 16; n++) blk[127 - 8 * n -: 8] = s[n % 4][n / 4];
    return blk;
  endfunction

  // Transaction-level reference: remaining-cycle count per accepted block.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [127:0] m_out  = '0;
  logic [127:0] m_pend = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0; m_done = 1'b0; m_out = '0;
      end else begin
        m_done = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            m_out  = m_pend;
          end
        end else if (i_start) begin
          m_left = 10;
          m_pend = model_dec(i_data_in, ks);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 128'(o_busy), 128'(m_left > 0));
      check("done", 128'(o_done), 128'(m_done));
      check("rk_idx", 128'(o_rk_idx), (m_left > 0) ? 128'(m_left - 1) : 128'd10);
      check("data_out", o_data_out, m_out);
      if (o_done) done_cnt++;
    end
  end

  logic [3:0] rkq[$];

  // When now=1 the start is driven at the current negedge (e.g. the done cycle).
  task automatic run_block(input logic [127:0] ct, input bit now, output logic [127:0] pt,
                           output int lat);
    if (!now) @(negedge clk);
    i_start = 1'b1; i_data_in = ct;
    rkq.delete();
    rkq.push_back(o_rk_idx);
    @(negedge clk);
    i_start = 1'b0;
    lat = 0;
    while (!o_done && lat < 20) begin
      rkq.push_back(o_rk_idx);
      @(negedge clk);
      lat++;
    end
    pt = o_data_out;
    check("latency", 128'(lat), 128'd10);
  endtask

  logic [127:0] pt1, pt2;
  int lat, dc0;

  initial begin
    for (int x = 0; x < 256; x++) begin
      sb[x] = sbox_fwd(8'(x));
      isb[sb[x]] = 8'(x);
    end
    expand(1'b0, C1Key);
    expand(1'b1, BKey);
    check("model_rk10_c1", rk_tab[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model_rk10_b", rk_tab[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_dec_c1", model_dec(C1Ct, 1'b0), C1Pt);
    check("model_dec_b", model_dec(BCt, 1'b1), BPt);

    @(negedge clk);
    check("rst_busy", 128'(o_busy), 128'd0);
    check("rst_done", 128'(o_done), 128'd0);
    check("rst_rk_idx", 128'(o_rk_idx), 128'd10);
    check("rst_data_out", o_data_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    repeat (50) @(negedge clk);
    check("idle_no_done", 128'(done_cnt), 128'd0);

    ks = 1'b0;
    run_block(C1Ct, 1'b0, pt1, lat);
    check("c1_plaintext", pt1, C1Pt);
    check("c1_rkq_len", 128'(rkq.size()), 128'd11);
    for (int i = 0; i < rkq.size(); i++) check("c1_rk_seq", 128'(rkq[i]), 128'(10 - i));

    run_block(C1Ct, 1'b1, pt2, lat);
    check("b2b_plaintext", pt2, C1Pt);

    repeat (3) @(negedge clk);
    ks = 1'b1;
    run_block(BCt, 1'b0, pt1, lat);
    check("appb_plaintext", pt1, BPt);

    repeat (2) @(negedge clk);
    ks = 1'b0;
    i_start = 1'b1; i_data_in = C1Ct;
    @(negedge clk);
    i_start = 1'b0;
    dc0 = done_cnt;
    lat = 0;
    while (!o_done && lat < 20) begin
      if (lat >= 1) check("busy_held", 128'(o_busy), 128'd1);
      i_start = (lat == 3 || lat == 7);
      i_data_in = BCt;
      @(negedge clk);
      lat++;
    end
    i_start = 1'b0;
    check("ign_latency", 128'(lat), 128'd10);
    check("ign_plaintext", o_data_out, C1Pt);
    repeat (12) @(negedge clk);
    check("ign_single_done", 128'(done_cnt - dc0), 128'd1);

    i_start = 1'b1; i_data_in = C1Ct;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    dc0 = done_cnt;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(o_busy), 128'd0);
    check("abort_done", 128'(o_done), 128'd0);
    check("abort_rk_idx", 128'(o_rk_idx), 128'd10);
    check("abort_data_out", o_data_out, '0);
    repeat (12) @(negedge clk);
    check("abort_no_done", 128'(done_cnt - dc0), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(C1Ct, 1'b0, pt1, lat);
    check("post_reset_plaintext", pt1, C1Pt);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
